// File: rtl/mode_record_pkg.sv
// mode_record_pkg: note codes, LED one-hot constants, default buffer size and FSM state type
// shared by the mode_record slice. Port summary: none (package only).
package mode_record_pkg;
   localparam logic [3:0] music0 = 4'd0, music1 = 4'd1, music2 = 4'd2, music3 = 4'd3,
                          music4 = 4'd4, music5 = 4'd5, music6 = 4'd6, music7 = 4'd7;
   localparam logic [3:0] END_CODE = 4'b1111;
   localparam logic [6:0] LED_REST = 7'b0000000, LED1 = 7'b0000001, LED2 = 7'b0000010,
                          LED3 = 7'b0000100, LED4 = 7'b0001000, LED5 = 7'b0010000,
                          LED6 = 7'b0100000, LED7 = 7'b1000000;
   localparam int SONG_TIME = 56;
   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, FINISH} state_t;
   // isolates the lowest set key so the lowest note wins when several are held
   function automatic logic [6:0] lowest_key(input logic [6:0] sw);
      return sw & (~sw + 7'd1);
   endfunction
   function automatic logic [3:0] led_to_note(input logic [6:0] led);
      case (led)
         LED1:    return music1;
         LED2:    return music2;
         LED3:    return music3;
         LED4:    return music4;
         LED5:    return music5;
         LED6:    return music6;
         LED7:    return music7;
         default: return music0;
      endcase
   endfunction
endpackage

// File: rtl/mode_record_switch_debounce.sv
// switch_debounce: 7-bit key debouncer, a bit follows its input only after STABLE equal cycles.
// Ports: clk, reset (sync, active-high), raw[6:0] keys in, clean[6:0] debounced keys out.
// Only built when REC_DEBOUNCE_EN is defined, since mode_record instantiates it only then.
`ifdef REC_DEBOUNCE_EN
module switch_debounce #(
   parameter int STABLE = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] raw,
   output logic [6:0] clean
);
   localparam int CW = $clog2(STABLE + 1);
   for (genvar b = 0; b < 7; b++) begin : g_bit
      logic [CW-1:0] cnt;
      logic          q;
      // the count runs only while the input disagrees, so any bounce back restarts it
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt <= '0;
            q   <= 1'b0;
         end else if (raw[b] == q) begin
            cnt <= '0;
         end else if (cnt == CW'(STABLE - 1)) begin
            cnt <= '0;
            q   <= raw[b];
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
      assign clean[b] = q;
   end
endmodule
`endif

// File: rtl/mode_record.sv
// mode_record: records played notes, octaves and durations into a packed song buffer.
// Ports: clk, reset (sync, active-high), switches[6:0] note keys, octave_in[1:0],
//   rec_btn[1:0] (bit0 start, bit1 stop, rising edge), song/octave/continue_packed buffers,
//   note_count, recording, full, and live note_to_play/octave_out/led_out for the buzzer.
// Option: define REC_DEBOUNCE_EN to debounce switches (SECOND/100 stable cycles).
module mode_record #(
   parameter int SECOND    = 10000000,
   parameter int SONG_TIME = mode_record_pkg::SONG_TIME
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [6:0]             switches,
   input  logic [1:0]             octave_in,
   input  logic [1:0]             rec_btn,
   output logic [SONG_TIME*4-1:0] song_packed,
   output logic [SONG_TIME*2-1:0] octave_packed,
   output logic [SONG_TIME*4-1:0] continue_packed,
   output logic [5:0]             note_count,
   output logic                   recording,
   output logic                   full,
   output logic [3:0]             note_to_play,
   output logic [1:0]             octave_out,
   output logic [6:0]             led_out
);
   import mode_record_pkg::*;

   localparam int         TW   = $clog2(SECOND + 1);
   localparam logic [5:0] LAST = 6'(SONG_TIME - 1);

   logic [6:0]    keys;
   state_t        state;
   logic [5:0]    idx, next_idx;
   logic [3:0]    units, held_note, dur;
   logic [1:0]    held_oct, btn_prev, rise;
   logic [TW-1:0] ticks;
   logic          key_diff, commit, wrap, at_last;
   logic [3:0]    song_mem [SONG_TIME];
   logic [1:0]    oct_mem  [SONG_TIME];
   logic [3:0]    cont_mem [SONG_TIME];

`ifdef REC_DEBOUNCE_EN
   switch_debounce #(.STABLE(SECOND / 100 > 0 ? SECOND / 100 : 1)) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (switches),
      .clean (keys)
   );
`else
   assign keys = switches;
`endif

   // the registered encoding is both the live buzzer output and what the FSM records
   always_ff @(posedge clk) begin
      if (reset) begin
         note_to_play <= music0;
         octave_out   <= 2'd0;
         led_out      <= LED_REST;
      end else begin
         note_to_play <= led_to_note(lowest_key(keys));
         octave_out   <= octave_in;
         led_out      <= lowest_key(keys);
      end
   end

   always_comb begin
      rise     = rec_btn & ~btn_prev;
      key_diff = {note_to_play, octave_out} != {held_note, held_oct};
      commit   = state == CAPTURE && (rise[1] || key_diff || units == 4'd15);
      dur      = units == 4'd0 ? 4'd1 : units;
      wrap     = ticks == TW'(SECOND - 1);
      next_idx = idx + 6'd1;
      at_last  = next_idx == LAST;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         units     <= '0;
         ticks     <= '0;
         held_note <= '0;
         held_oct  <= '0;
         btn_prev  <= '0;
         full      <= 1'b0;
         recording <= 1'b0;
      end else begin
         btn_prev <= rec_btn;
         case (state)
            IDLE: if (rise[0]) begin
               state     <= ARM;
               recording <= 1'b1;
               idx       <= '0;
               full      <= 1'b0;
            end
            ARM: if (rise[1]) begin
               state     <= FINISH;
               recording <= 1'b0;
            end else if (note_to_play != music0) begin
               state     <= CAPTURE;
               held_note <= note_to_play;
               held_oct  <= octave_out;
               units     <= '0;
               ticks     <= '0;
            end
            CAPTURE: if (commit) begin
               // a 15-unit split reloads the same pair, so one reload covers every commit
               idx       <= next_idx;
               held_note <= note_to_play;
               held_oct  <= octave_out;
               units     <= '0;
               ticks     <= '0;
               if (at_last) full <= 1'b1;
               if (rise[1] || at_last) begin
                  state     <= FINISH;
                  recording <= 1'b0;
               end
            end else if (wrap) begin
               ticks <= '0;
               units <= units + 4'd1;
            end else begin
               ticks <= ticks + TW'(1);
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < SONG_TIME; i++) begin
         if (reset || (state == IDLE && rise[0])) begin
            song_mem[i] <= '0;
            oct_mem[i]  <= '0;
            cont_mem[i] <= '0;
         end else if (6'(i) == idx && commit) begin
            song_mem[i] <= held_note;
            oct_mem[i]  <= held_oct;
            cont_mem[i] <= dur;
         end else if (6'(i) == idx && state == FINISH) begin
            song_mem[i] <= END_CODE;
            oct_mem[i]  <= 2'd0;
            cont_mem[i] <= 4'd0;
         end
      end
   end

   for (genvar e = 0; e < SONG_TIME; e++) begin : g_pack
      assign song_packed[4*e +: 4]     = song_mem[e];
      assign octave_packed[2*e +: 2]   = oct_mem[e];
      assign continue_packed[4*e +: 4] = cont_mem[e];
   end

   assign note_count = idx;
endmodule
